// File: rtl/rangles_if.sv
`timescale 1ns/1ps
// rangles_if: request/result bundle between a matrix source and the rangles angle extractor.
// Latency: none, wires only.
// Backpressure: none; the source must honour busy, requests made while busy are dropped.
interface rangles_if;
  logic               validIn;
  logic signed [15:0] R31;
  logic signed [15:0] R32;
  logic signed [15:0] R33;
  logic signed [12:0] Rx;
  logic signed [12:0] Ry;
  logic               validOut;
  logic               busy;
  logic               clamped;

  modport master (
    output validIn, R31, R32, R33,
    input  Rx, Ry, validOut, busy, clamped
  );

  modport slave (
    input  validIn, R31, R32, R33,
    output Rx, Ry, validOut, busy, clamped
  );
endinterface

// File: rtl/rangles.sv
`timescale 1ns/1ps
// rangles: Rx = atan2(R32,R33), Ry = atan2(-R31, |(R32,R33)|) via one shared vectoring CORDIC.
// Latency: validOut 23 clock edges after the edge that samples validIn; Rx/Ry hold between results.
// Backpressure: none; validIn while busy (DONE included) is dropped. Optional clamp: RANGLES_CLAMP_EN.
module rangles #(
  parameter logic signed [12:0] LIMIT = 13'sd170
) (
  input  logic     clock,
  input  logic     reset,
  rangles_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PRE1, ITER1, PRE2, ITER2, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [3:0]         iter;
  logic signed [15:0] r31;
  logic signed [15:0] r32;
  logic signed [15:0] r33;
  logic signed [19:0] x;
  logic signed [19:0] y;
  logic signed [12:0] z;
  logic signed [12:0] z1;
  logic signed [19:0] x_shift;
  logic signed [19:0] y_shift;
  logic signed [19:0] x_next;
  logic signed [19:0] y_next;
  logic signed [12:0] z_next;
  logic signed [19:0] pre1_x;
  logic signed [19:0] pre1_y;
  logic signed [12:0] pre1_z;
  logic signed [19:0] neg_r31;
  logic signed [19:0] pre2_y;
  logic signed [12:0] rx_sat;
  logic signed [12:0] ry_sat;
  logic signed [12:0] rx_res;
  logic signed [12:0] ry_res;
  logic               clamp_hit;
  logic signed [12:0] rx_q;
  logic signed [12:0] ry_q;
  logic               valid_q;
  logic               clamped_q;

  // atan(2^-i) in units of pi/1024.
  function automatic logic signed [12:0] atan_step(input logic [3:0] i);
    case (i)
      4'd0:    atan_step = 13'sd256;
      4'd1:    atan_step = 13'sd151;
      4'd2:    atan_step = 13'sd80;
      4'd3:    atan_step = 13'sd41;
      4'd4:    atan_step = 13'sd20;
      4'd5:    atan_step = 13'sd10;
      4'd6:    atan_step = 13'sd5;
      4'd7:    atan_step = 13'sd3;
      4'd8:    atan_step = 13'sd1;
      4'd9:    atan_step = 13'sd1;
      default: atan_step = 13'sd0;
    endcase
  endfunction

  // Pass-1 z can reach about +/-1600; the output range is one turn, [-1024, 1023].
  function automatic logic signed [12:0] wrap_sat(input logic signed [12:0] a);
    if (a > 13'sd1023)       wrap_sat = 13'sd1023;
    else if (a < -13'sd1024) wrap_sat = -13'sd1024;
    else                     wrap_sat = a;
  endfunction

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Sequencing: each ITER state runs exactly ten micro-rotations (iter 0..9).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.validIn) state_next = PRE1;
      PRE1:    state_next = ITER1;
      ITER1:   if (iter == 4'd9) state_next = PRE2;
      PRE2:    state_next = ITER2;
      ITER2:   if (iter == 4'd9) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One vectoring micro-rotation, both updates from the pre-iteration x and y.
  always_comb begin
    x_shift = x >>> iter;
    y_shift = y >>> iter;
    if (!y[19]) begin
      x_next = x + y_shift;
      y_next = y - x_shift;
      z_next = z + atan_step(iter);
    end else begin
      x_next = x - y_shift;
      y_next = y + x_shift;
      z_next = z - atan_step(iter);
    end
  end

  // Pass setup: left half-plane folded by pi for pass 1; pass 2 scales -R31 by ~K to match x.
  always_comb begin
    pre1_x = 20'(r33);
    pre1_y = 20'(r32);
    pre1_z = 13'sd0;
    if (r33[15]) begin
      pre1_x = -20'(r33);
      pre1_y = -20'(r32);
      pre1_z = r32[15] ? -13'sd1024 : 13'sd1024;
    end
    neg_r31 = -20'(r31);
    pre2_y  = neg_r31 + (neg_r31 >>> 1) + (neg_r31 >>> 3) + (neg_r31 >>> 6) + (neg_r31 >>> 7);
  end

  // Final angles: a zero vector has no direction, so those cases are forced to zero.
  always_comb begin
    rx_sat = (r32 == '0 && r33 == '0) ? 13'sd0 : wrap_sat(z1);
    ry_sat = (r31 == '0 && r32 == '0 && r33 == '0) ? 13'sd0 : wrap_sat(z);
  end

`ifdef RANGLES_CLAMP_EN
  // Symmetric clamp to +/-LIMIT; clamp_hit records whether either angle was limited.
  always_comb begin
    rx_res    = rx_sat;
    ry_res    = ry_sat;
    clamp_hit = 1'b0;
    if (rx_sat > LIMIT) begin
      rx_res    = LIMIT;
      clamp_hit = 1'b1;
    end else if (rx_sat < -LIMIT) begin
      rx_res    = -LIMIT;
      clamp_hit = 1'b1;
    end
    if (ry_sat > LIMIT) begin
      ry_res    = LIMIT;
      clamp_hit = 1'b1;
    end else if (ry_sat < -LIMIT) begin
      ry_res    = -LIMIT;
      clamp_hit = 1'b1;
    end
  end
`else
  // Clamp not built: angles pass straight through; LIMIT has no effect in this build.
  logic unused_limit;
  assign unused_limit = ^LIMIT;
  assign rx_res       = rx_sat;
  assign ry_res       = ry_sat;
  assign clamp_hit    = 1'b0;
`endif

  // Datapath: operand capture, pass setup, micro-rotations and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      iter      <= '0;
      r31       <= '0;
      r32       <= '0;
      r33       <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      z1        <= '0;
      rx_q      <= '0;
      ry_q      <= '0;
      valid_q   <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      clamped_q <= 1'b0;
      case (state)
        IDLE: begin
          iter <= '0;
          if (bus.validIn) begin
            r31 <= bus.R31;
            r32 <= bus.R32;
            r33 <= bus.R33;
          end
        end
        PRE1: begin
          x    <= pre1_x;
          y    <= pre1_y;
          z    <= pre1_z;
          iter <= '0;
        end
        ITER1, ITER2: begin
          x    <= x_next;
          y    <= y_next;
          z    <= z_next;
          iter <= iter + 4'd1;
        end
        PRE2: begin
          z1   <= z;
          y    <= pre2_y;
          z    <= '0;
          iter <= '0;
        end
        DONE: begin
          rx_q      <= rx_res;
          ry_q      <= ry_res;
          valid_q   <= 1'b1;
          clamped_q <= clamp_hit;
        end
        default: ;
      endcase
    end
  end

  assign bus.Rx       = rx_q;
  assign bus.Ry       = ry_q;
  assign bus.validOut = valid_q;
  assign bus.busy     = (state != IDLE);
  assign bus.clamped  = clamped_q;

endmodule

// File: tb/tb_rangles.sv
`timescale 1ns/1ps
// tb_rangles: drives rotation matrices into rangles and checks every cycle against a real-math model.
// Model: accepted request -> result 23 edges later, angles from $atan2 rounded to pi/1024 units.
// Directed cases pin literal results; random cases use generated Rx/Ry angle pairs.
module tb_rangles;
  localparam real PI  = 3.141592653589793;
  localparam int  LAT = 23;
  localparam int  LIM = 170;
`ifdef RANGLES_CLAMP_EN
  localparam bit CLAMP_ON = 1'b1;
`else
  localparam bit CLAMP_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  rangles_if bus();
  rangles dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int tol      = 2;

  task automatic chk(input string name, input int act, input int exp, input int t);
    n_checks++;
    if (act > exp + t || act < exp - t) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d) at %0t", name, act, exp, t, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int to_units(input real a);
    return $rtoi($floor(a * 1024.0 / PI + 0.5));
  endfunction

  function automatic int sat_turn(input int v);
    if (v > 1023)  return 1023;
    if (v < -1024) return -1024;
    return v;
  endfunction

  function automatic int raw_rx(input int r32, input int r33);
    if (r32 == 0 && r33 == 0) return 0;
    return sat_turn(to_units($atan2(real'(r32), real'(r33))));
  endfunction

  function automatic int raw_ry(input int r31, input int r32, input int r33);
    real m;
    if (r31 == 0 && r32 == 0 && r33 == 0) return 0;
    m = $sqrt(real'(r32) * real'(r32) + real'(r33) * real'(r33));
    return sat_turn(to_units($atan2(-real'(r31), m)));
  endfunction

  function automatic int lim(input int v);
    if (CLAMP_ON && v > LIM)  return LIM;
    if (CLAMP_ON && v < -LIM) return -LIM;
    return v;
  endfunction

  function automatic bit lim_hit(input int a, input int b);
    return CLAMP_ON && (iabs(a) > LIM || iabs(b) > LIM);
  endfunction

  // Near the clamp boundary the reference rounding cannot decide the flag.
  function automatic bit lim_amb(input int a, input int b);
    return CLAMP_ON && (iabs(iabs(a) - LIM) <= 4 || iabs(iabs(b) - LIM) <= 4);
  endfunction

  // Reference model: one request in flight, result published LAT edges after acceptance.
  int pend = 0;
  int pend_rx = 0, pend_ry = 0, pend_tol = 0;
  bit pend_clamp = 1'b0, pend_amb = 1'b0;
  int hold_rx = 0, hold_ry = 0, hold_tol = 0;
  bit hold_amb = 1'b0, exp_vld = 1'b0, exp_clamp = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pend      <= 0;
      exp_vld   <= 1'b0;
      exp_clamp <= 1'b0;
      hold_rx   <= 0;
      hold_ry   <= 0;
      hold_tol  <= 0;
      hold_amb  <= 1'b0;
    end else begin
      exp_vld   <= 1'b0;
      exp_clamp <= 1'b0;
      if (pend > 0) begin
        pend <= pend - 1;
        if (pend == 1) begin
          exp_vld   <= 1'b1;
          exp_clamp <= pend_clamp;
          hold_rx   <= pend_rx;
          hold_ry   <= pend_ry;
          hold_tol  <= pend_tol;
          hold_amb  <= pend_amb;
        end
      end else if (bus.validIn) begin
        pend       <= LAT;
        pend_rx    <= lim(raw_rx(bus.R32, bus.R33));
        pend_ry    <= lim(raw_ry(bus.R31, bus.R32, bus.R33));
        pend_clamp <= lim_hit(raw_rx(bus.R32, bus.R33), raw_ry(bus.R31, bus.R32, bus.R33));
        pend_amb   <= lim_amb(raw_rx(bus.R32, bus.R33), raw_ry(bus.R31, bus.R32, bus.R33));
        pend_tol   <= tol;
      end
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      chk("validOut", int'(bus.validOut), int'(exp_vld), 0);
      chk("busy", int'(bus.busy), int'(pend > 0), 0);
      chk("Rx_hold", bus.Rx, hold_rx, hold_tol);
      chk("Ry_hold", bus.Ry, hold_ry, hold_tol);
      if (!(exp_vld && hold_amb)) chk("clamped", int'(bus.clamped), int'(exp_clamp), 0);
    end
  end

  // Issue one request at posedge+1; returns at posedge+1 of the validOut cycle (or after 40 edges).
  task automatic drive_txn(input int r31, input int r32, input int r33, input int t, input int spur,
                           output int lat, output int busy_cyc);
    tol         = t;
    bus.R31     = 16'(r31);
    bus.R32     = 16'(r32);
    bus.R33     = 16'(r33);
    bus.validIn = 1'b1;
    @(posedge clock);
    #1;
    bus.validIn = 1'b0;
    bus.R31     = 16'($urandom);
    bus.R32     = 16'($urandom);
    bus.R33     = 16'($urandom);
    lat         = 0;
    busy_cyc    = int'(bus.busy);
    while (!bus.validOut && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
      busy_cyc += int'(bus.busy);
      bus.validIn = (lat == spur);
      if (bus.validIn) begin
        bus.R31 = 16'($urandom);
        bus.R32 = 16'($urandom);
        bus.R33 = 16'($urandom);
      end
    end
    bus.validIn = 1'b0;
  endtask

  task automatic count_vout(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
      n += int'(bus.validOut);
    end
  endtask

  initial begin
    int  lat, bc, nv, r31, r32, r33, gap;
    real ax, ay;
    bus.validIn = 1'b0;
    bus.R31     = '0;
    bus.R32     = '0;
    bus.R33     = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_Rx", bus.Rx, 0, 0);
    chk("reset_Ry", bus.Ry, 0, 0);
    chk("reset_validOut", int'(bus.validOut), 0, 0);
    chk("reset_busy", int'(bus.busy), 0, 0);
    chk("reset_clamped", int'(bus.clamped), 0, 0);
    reset = 1'b0;

    chk("pin_model_rx30", raw_rx(-7094, 12288), -171, 0);
    chk("pin_model_ry30", raw_ry(-8192, -7094, 12288), 171, 0);
    chk("pin_model_rx180", raw_rx(0, -16384), 1023, 0);
    chk("pin_model_ry_down", raw_ry(16384, 0, 0), -512, 0);
    chk("pin_model_rx_degen", raw_rx(0, 0), 0, 0);

    drive_txn(0, 0, 16384, 2, 0, lat, bc);
    chk("identity_latency", lat, LAT, 0);
    chk("identity_Rx", bus.Rx, 0, 2);
    chk("identity_Ry", bus.Ry, 0, 2);

    drive_txn(-8192, -7094, 12288, 2, 0, lat, bc);
    chk("deg30_latency", lat, LAT, 0);
    chk("deg30_busy_cycles", bc, LAT, 0);
    chk("deg30_Rx", bus.Rx, -171, 2);
    chk("deg30_Ry", bus.Ry, 170, 2);

    drive_txn(0, 0, -16384, 2, 0, lat, bc);
    chk("quadrant_latency", lat, LAT, 0);
    chk("quadrant_Rx", bus.Rx, CLAMP_ON ? LIM : 1023, 2);
    chk("quadrant_Ry", bus.Ry, 0, 2);
    chk("quadrant_clamped", int'(bus.clamped), int'(CLAMP_ON), 0);

    drive_txn(0, 0, 0, 0, 0, lat, bc);
    chk("zero_latency", lat, LAT, 0);
    chk("zero_Rx", bus.Rx, 0, 0);
    chk("zero_Ry", bus.Ry, 0, 0);
    chk("zero_clamped", int'(bus.clamped), 0, 0);

    // Second request five edges into the first one must be dropped.
    drive_txn(-8192, -7094, 12288, 2, 4, lat, bc);
    chk("reject_latency", lat, LAT, 0);
    chk("reject_Rx", bus.Rx, -171, 2);
    chk("reject_Ry", bus.Ry, 170, 2);
    count_vout(30, nv);
    chk("reject_extra_validOut", nv, 0, 0);

    // Reset twelve edges into a computation.
    tol         = 2;
    bus.R31     = 16'(-8192);
    bus.R32     = 16'(7094);
    bus.R33     = 16'(12288);
    bus.validIn = 1'b1;
    @(posedge clock);
    #1;
    bus.validIn = 1'b0;
    repeat (12) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_Rx", bus.Rx, 0, 0);
    chk("midreset_Ry", bus.Ry, 0, 0);
    chk("midreset_busy", int'(bus.busy), 0, 0);
    chk("midreset_validOut", int'(bus.validOut), 0, 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    count_vout(30, nv);
    chk("midreset_no_validOut", nv, 0, 0);
    drive_txn(0, 7094, 12288, 2, 0, lat, bc);
    chk("after_reset_latency", lat, LAT, 0);
    chk("after_reset_Rx", bus.Rx, 171, 2);

    // Random rotation matrices built from Rx in [-170,170] deg, Ry in [-60,60] deg.
    for (int k = 0; k < 40; k++) begin
      ax  = (real'($urandom_range(0, 3400)) / 10.0 - 170.0) * PI / 180.0;
      ay  = (real'($urandom_range(0, 1200)) / 10.0 - 60.0) * PI / 180.0;
      r31 = $rtoi($floor(-$sin(ay) * 16384.0 + 0.5));
      r32 = $rtoi($floor($cos(ay) * $sin(ax) * 16384.0 + 0.5));
      r33 = $rtoi($floor($cos(ay) * $cos(ax) * 16384.0 + 0.5));
      drive_txn(r31, r32, r33, 4, (k % 2 == 1) ? int'($urandom_range(1, 22)) : 0, lat, bc);
      chk("random_latency", lat, LAT, 0);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(posedge clock);
        #1;
      end
    end

    repeat (3) @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected to end before 1 ms", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
